// File: rtl/l2c_rsp_rx.sv
// rtl/l2c_rsp_rx.sv - L2C response receiver: uid filter, response FIFO, credit return
// Beats for this core are buffered and handed to the pipeline; each consumed entry returns one credit.
`ifndef CORE_UID_W
`define CORE_UID_W 8
`endif
`ifndef CORE_DATA_W
`define CORE_DATA_W 64
`endif

module l2c_rsp_rx #(
    parameter int DEPTH   = 4,
    parameter int UID_W   = `CORE_UID_W,
    parameter int DATA_W  = `CORE_DATA_W,
    parameter int CORE_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic [UID_W-1:0]           uid,
    input  logic [DATA_W-1:0]          data,
    output logic                       credit_ret,
    output logic                       rsp_valid,
    output logic [UID_W-1:0]           rsp_uid,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       rsp_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [UID_W-1:0]  mem_uid  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    // The extra MSB on each pointer separates full (MSBs differ) from empty.
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic acc;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign acc   = rdy && (uid == UID_W'(CORE_ID));
    assign count = wptr - rptr;
    assign full  = (count == PW'(DEPTH));

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    // A full FIFO still takes a beat when the head leaves on the same edge.
    assign push = acc && (!full || pop);
    assign drop = acc && full && !pop;

    // Outputs are forced to zero while empty so stale memory never leaks out.
    assign rsp_uid  = rsp_valid ? mem_uid[rptr[AW-1:0]]  : '0;
    assign rsp_data = rsp_valid ? mem_data[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_uid[wptr[AW-1:0]]  <= uid;
            mem_data[wptr[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            credit_ret <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            credit_ret <= pop;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l2c_rsp_rx.sv
// tb/tb_l2c_rsp_rx.sv - self-checking bench for l2c_rsp_rx against a queue-based model
module tb_l2c_rsp_rx;

    localparam int DEPTH  = 4;
    localparam int UID_W  = 4;
    localparam int DATA_W = 8;
    localparam int CID    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [UID_W-1:0]  uid;
    logic [DATA_W-1:0] data;
    logic              credit_ret;
    logic              rsp_valid;
    logic [UID_W-1:0]  rsp_uid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic [2:0]        count;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q[$];
    bit m_ovf;
    bit m_credit;

    l2c_rsp_rx #(.DEPTH(DEPTH), .UID_W(UID_W), .DATA_W(DATA_W), .CORE_ID(CID)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .uid(uid), .data(data),
        .credit_ret(credit_ret), .rsp_valid(rsp_valid), .rsp_uid(rsp_uid),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic tick;
        bit p, a, f;
        p = (q.size() != 0) && rsp_ready;
        a = rdy && (uid == UID_W'(CID));
        f = (q.size() == DEPTH);
        if (p) void'(q.pop_front());
        if (a) begin
            if (!f || p) q.push_back(data);
            else m_ovf = 1'b1;
        end
        m_credit = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rdy = 1'b0; uid = '0; data = '0; rsp_ready = 1'b0;
        rst = 1'b1;
        q.delete(); m_ovf = 1'b0; m_credit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d);
        rdy = 1'b1; uid = UID_W'(CID); data = d;
        tick();
        rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; uid = UID_W'(CID); data = 8'h3C; rsp_ready = 1'b0;
        q.delete(); m_ovf = 1'b0; m_credit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b0;
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (credit_ret !== 1'b0) begin errors++; $display("FAIL reset_credit got %b exp 0", credit_ret); end
        checks++; if (rsp_data !== '0 || rsp_uid !== '0) begin errors++; $display("FAIL reset_outputs got uid %h data %h exp 0 0", rsp_uid, rsp_data); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_idle_count got %0d exp 0", count); end
    endtask

    task automatic test_filter;
        logic [UID_W-1:0]  fu[3];
        logic [DATA_W-1:0] fd[3];
        logic [DATA_W-1:0] fx[2];
        fu[0] = 4'd2; fu[1] = 4'd3; fu[2] = 4'd2;
        fd[0] = 8'hA5; fd[1] = 8'h11; fd[2] = 8'h5A;
        fx[0] = 8'hA5; fx[1] = 8'h5A;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b1; uid = fu[i]; data = fd[i];
            tick();
        end
        rdy = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL filter_count got %0d exp 2", count); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== fx[i] || rsp_uid !== UID_W'(CID)) begin
                errors++; $display("FAIL filter_head%0d got v%b uid %h data %h exp v1 uid %h data %h", i, rsp_valid, rsp_uid, rsp_data, CID, fx[i]);
            end
            tick();
            checks++; if (credit_ret !== 1'b1) begin errors++; $display("FAIL filter_credit%0d got %b exp 1", i, credit_ret); end
        end
        rsp_ready = 1'b0;
        tick();
        checks++; if (credit_ret !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL filter_idle got credit %b valid %b exp 0 0", credit_ret, rsp_valid); end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(DATA_W'(i));
        checks++; if (count !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill got count %0d ovf %b exp 4 0", count, ovf); end
        push_beat(8'h99);
        checks++; if (count !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_drop got count %0d ovf %b exp 4 1", count, ovf); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data !== DATA_W'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, rsp_data, i); end
            tick();
        end
        rsp_ready = 1'b0;
        checks++; if (count !== 3'd0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got count %0d ovf %b exp 0 1", count, ovf); end
    endtask

    task automatic test_full_pop;
        logic [DATA_W-1:0] tail[4];
        tail[0] = 8'h11; tail[1] = 8'h12; tail[2] = 8'h13; tail[3] = 8'h77;
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(DATA_W'(8'h10 + i));
        rdy = 1'b1; uid = UID_W'(CID); data = 8'h77; rsp_ready = 1'b1;
        checks++; if (rsp_data !== 8'h10) begin errors++; $display("FAIL fullpop_head got %h exp 10", rsp_data); end
        tick();
        rdy = 1'b0;
        checks++; if (count !== 3'd4 || ovf !== 1'b0 || credit_ret !== 1'b1) begin
            errors++; $display("FAIL fullpop_state got count %0d ovf %b credit %b exp 4 0 1", count, ovf, credit_ret);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data !== tail[i]) begin errors++; $display("FAIL fullpop_drain%0d got %h exp %h", i, rsp_data, tail[i]); end
            tick();
        end
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got valid %b exp 0", rsp_valid); end
    endtask

    task automatic test_stream;
        int credits;
        credits = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin rdy = 1'b1; uid = UID_W'(CID); data = DATA_W'(c); end
            else rdy = 1'b0;
            if (c >= 1 && c <= 20) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(c - 1)) begin
                    errors++; $display("FAIL stream_out%0d got v%b data %h exp v1 data %h", c, rsp_valid, rsp_data, c - 1);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_idle%0d got valid %b exp 0", c, rsp_valid); end
            end
            checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count%0d got %0d exp <=1", c, count); end
            tick();
            if (credit_ret === 1'b1) credits++;
        end
        rsp_ready = 1'b0;
        checks++; if (credits != 20) begin errors++; $display("FAIL stream_credits got %0d exp 20", credits); end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 0; i < 3; i++) push_beat(DATA_W'(8'hC0 + i));
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre got %0d exp 3", count); end
        #3 rst = 1'b1;
        q.delete(); m_ovf = 1'b0; m_credit = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || rsp_valid !== 1'b0 || credit_ret !== 1'b0) begin
            errors++; $display("FAIL areset_now got count %0d valid %b credit %b exp 0 0 0", count, rsp_valid, credit_ret);
        end
        #6 rst = 1'b0;
        tick();
        checks++; if (credit_ret !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL areset_after got credit %b count %0d exp 0 0", credit_ret, count); end
        push_beat(8'hE1);
        push_beat(8'hE2);
        rsp_ready = 1'b1;
        checks++; if (rsp_data !== 8'hE1) begin errors++; $display("FAIL areset_resume0 got %h exp e1", rsp_data); end
        tick();
        checks++; if (rsp_data !== 8'hE2 || credit_ret !== 1'b1) begin errors++; $display("FAIL areset_resume1 got %h credit %b exp e2 1", rsp_data, credit_ret); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 9) < 6);
            uid = ($urandom_range(0, 3) == 0) ? UID_W'($urandom) : UID_W'(CID);
            data = DATA_W'($urandom);
            rsp_ready = (c < 300) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) < 9);
            checks++; if (rsp_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid%0d got %b exp %b", c, rsp_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (rsp_data !== q[0] || rsp_uid !== UID_W'(CID)) begin
                    errors++; $display("FAIL rand_head%0d got uid %h data %h exp uid %h data %h", c, rsp_uid, rsp_data, CID, q[0]);
                end
            end
            tick();
            checks++; if (count !== 3'(q.size()) || credit_ret !== m_credit || ovf !== m_ovf) begin
                errors++; $display("FAIL rand_state%0d got count %0d credit %b ovf %b exp %0d %b %b", c, count, credit_ret, ovf, q.size(), m_credit, m_ovf);
            end
        end
        rdy = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; uid = '0; data = '0; rsp_ready = 1'b0;
        test_reset();
        test_filter();
        test_overflow();
        test_full_pop();
        test_stream();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2c_rsp_rx.md
Name: l2c_rsp_rx

Overview:
Core-side receiver for the L2C response channel (rdy/uid/data). That channel carries a one-cycle valid pulse and has no backpressure.
- Filters beats addressed to this core by uid.
- Buffers accepted beats in a small FIFO and presents them to the core pipeline with a valid/ready handshake.
- Returns one credit pulse to the L2C per consumed entry, so the L2C never overruns the buffer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- UID_W, `CORE_UID_W, uid field width.
- DATA_W, `CORE_DATA_W, data field width.
- CORE_ID, 0, uid value this instance accepts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  L2C beat valid; single-cycle pulse, no backpressure.
- uid  in  UID_W  destination uid of the beat.
- data  in  DATA_W  beat payload.
- credit_ret  out  1  one-cycle pulse; returns one buffer credit to the L2C.
- rsp_valid  out  1  head entry available.
- rsp_uid  out  UID_W  uid of the head entry (always CORE_ID when valid).
- rsp_data  out  DATA_W  payload of the head entry.
- rsp_ready  in  1  core consumes the head entry.
- count  out  log2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky overflow error flag.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_uid=0, rsp_data=0, credit_ret=0, count=0, ovf=0.
  - Read and write pointers are 0.
  - Memory contents are don't-care.
  - Reset asserted mid-transfer discards all buffered entries. No credits are returned for them; the L2C resets its credit count to DEPTH on the same reset.
- Accept condition: acc = rdy && (uid == CORE_ID). Beats with any other uid are ignored, with no state change.
- Push:
  - On acc, write data/uid at wptr; wptr increments modulo DEPTH.
  - An extra pointer bit distinguishes full from empty.
- Pop:
  - pop = rsp_valid && rsp_ready; rptr increments modulo DEPTH.
  - rsp_ready while empty has no effect.
- Latency and outputs:
  - A beat accepted at edge N is visible as rsp_valid=1 after edge N. There is no same-cycle bypass.
  - rsp_valid = (count != 0).
  - rsp_uid and rsp_data are a combinational read of the entry at rptr. They hold stable while rsp_valid=1 and rsp_ready=0.
- Ordering: strict FIFO.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Full with pop in the same cycle: the push is accepted and count stays DEPTH.
- Full with no pop:
  - The beat is dropped and the FIFO state is unchanged.
  - ovf sets to 1 on the next edge and stays set until reset.
  - This condition is a protocol violation by the L2C.
- Empty with push and pop in the same cycle cannot occur, because rsp_valid=0 prevents the pop.
- Pointer wrap: after DEPTH pushes, wptr returns to slot 0 with its extra bit toggled. Data integrity across the wrap is required.
- credit_ret:
  - Registered; equals 1 for exactly the cycle after each pop edge.
  - Back-to-back pops produce back-to-back pulses.
  - Total pulses equal total pops since reset.
- No other state machine: the block is a pure FIFO plus flags. All flags update on the same edge as the pointers.

Test Plan:
1. Reset with rdy=1, uid=CORE_ID held during reset -> no entries, count=0, rsp_valid=0, ovf=0 after rst deasserts.
2. With CORE_ID=2: beats (uid=2, data=0xA5), (uid=3, 0x11), (uid=2, 0x5A) on consecutive cycles, rsp_ready=0 -> count=2. Then rsp_ready=1 -> rsp_data 0xA5 then 0x5A; two credit_ret pulses, each one cycle after its pop.
3. Fill: 4 matching beats 0..3 with rsp_ready=0 -> count=4. A 5th beat (0x99) with no pop -> dropped, ovf=1, count=4. Drain order is 0,1,2,3; ovf stays 1.
4. Full plus simultaneous: count=4, beat 0x77 arrives in the same cycle as rsp_ready=1 -> count stays 4, ovf=0. The drain tail ends with 0x77.
5. Streaming wrap: 20 matching beats with values 0..19 arrive every cycle, rsp_ready=1 throughout -> outputs 0..19 in order, each 1 cycle after its push. count never exceeds 1; 20 credit_ret pulses.
6. Mid-stream reset: count=3, assert rst for 1 cycle (asynchronous, between edges) -> count=0, rsp_valid=0 immediately. No credit_ret pulse; subsequent operation is normal.
